// File: rtl/pipe_fetch_if.sv
// Fetch-stage bundle: pipeline control, instruction-memory read port and the ir/pc output.
interface pipe_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;

    modport master (
        input  stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, ir, ir_valid, pc
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, ir, ir_valid, pc
    );
endinterface

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: PC, credit-limited in-order imem reads, prefetch FIFO, redirect drain.
// Optional FETCH_BYPASS_EN: a response arriving into an empty FIFO loads ir directly.
module pipe_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    pipe_fetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   ir_q, pc_q;
    logic          ir_valid_q;

    logic          req_c, grant, resp, credit, deliver, bypass, push, pop;
    logic [31:0]   resp_pc;

    // FIFO occupancy plus outstanding reads may never exceed DEPTH
    assign credit  = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
    // Oldest outstanding read was issued inflight words behind the current fetch pc
    assign resp_pc = fetch_pc_q - (32'(inflight_q) << 2);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_c      = 1'b0;
        resp       = 1'b0;
        unique case (state_q)
            IDLE:  state_d = RUN;
            RUN: begin
                req_c = credit && !bus.redirect;
                resp  = bus.imem_rvalid && (inflight_q != '0);
            end
            DRAIN: resp = bus.imem_rvalid && (inflight_q != '0);
            default: state_d = IDLE;
        endcase
        grant      = req_c && bus.imem_gnt;
        inflight_d = inflight_q + CW'(grant) - CW'(resp);
        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (state_q == DRAIN && inflight_d == '0) begin
            state_d = RUN;
        end
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            state_d    = (inflight_d != '0) ? DRAIN : RUN;
        end
    end

    assign deliver = (state_q == RUN) && resp && !bus.redirect;
`ifdef FETCH_BYPASS_EN
    assign bypass  = deliver && (count_q == '0) && !bus.stall;
`else
    assign bypass  = 1'b0;
`endif
    assign push    = deliver && !bypass;
    assign pop     = !bus.redirect && !bus.stall && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            if (bus.redirect) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                ir_q       <= '0;
                ir_valid_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
                if (!bus.stall) begin
                    if (bypass) begin
                        ir_q       <= bus.imem_rdata;
                        pc_q       <= resp_pc;
                        ir_valid_q <= 1'b1;
                    end else if (pop) begin
                        ir_q       <= fifo_q[rd_ptr_q].word;
                        pc_q       <= fifo_q[rd_ptr_q].pc;
                        ir_valid_q <= 1'b1;
                    end else begin
                        ir_q       <= '0;
                        ir_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: resp_pc, word: bus.imem_rdata};
        end
    end

    // A response into a full FIFO means the credit limit was broken
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (count_q < CW'(DEPTH));
        end
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc        = pc_q;
endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: in-order memory model with random latency/grant, plus a
// queue-level reference of FIFO occupancy, outstanding reads and the expected pc stream.
module tb_pipe_fetch;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'h5A5A_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    pipe_fetch_if bus ();

    pipe_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int since = 0;
    rd_t memq[$];
    logic [31:0] glog[$];
    int occ, drop, last_ready, issued;
    int first_grant, first_valid, last_drop_cyc, first_req_cyc, discard_cnt;
    bit req_watch;
    logic [31:0] exp_fetch, exp_issue, last_issue_pc;
    bit have_prev, prev_stall, prev_redirect, prev_deliver, prev_valid;
    int prev_occ;
    logic [31:0] prev_ir, prev_pc;
    bit rst_cmd, stall_cmd, redir_cmd;
    logic [31:0] redir_pc_cmd;
    int gnt_pct, lat_min, lat_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference update for one cycle, called after inputs settle and before the edge
    task automatic observe();
        int  occ_pre;
        int  r;
        bit  deliver;
        bit  exp_new;
        bit  exp_req;
        if (have_prev) begin
            if (prev_redirect) begin
                chk("redirect_bubble_ir", bus.ir, 32'h0);
                chk("redirect_bubble_valid", 32'(bus.ir_valid), 32'h0);
            end else if (prev_stall) begin
                chk("stall_hold_ir", bus.ir, prev_ir);
                chk("stall_hold_valid", 32'(bus.ir_valid), 32'(prev_valid));
                chk("stall_hold_pc", bus.pc, prev_pc);
            end else begin
                exp_new = (prev_occ > 0) || (BYP && prev_deliver);
                chk("ir_valid", 32'(bus.ir_valid), 32'(exp_new));
                if (exp_new) begin
                    chk("issue_pc", bus.pc, exp_issue);
                    chk("issue_ir", bus.ir, exp_issue ^ KEY);
                    last_issue_pc = bus.pc;
                    exp_issue += 32'd4;
                    occ--;
                    issued++;
                    if (first_valid < 0) first_valid = cyc;
                end else begin
                    chk("bubble_ir", bus.ir, 32'h0);
                    chk("bubble_pc_hold", bus.pc, prev_pc);
                end
            end
        end
        occ_pre = occ;
        exp_req = (since >= 1) && !bus.redirect && (drop == 0) && (occ + memq.size() < int'(DEPTH));
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (bus.imem_req) chk("imem_addr", bus.imem_addr, exp_fetch);
        if (bus.imem_req && req_watch) begin
            req_watch     = 1'b0;
            first_req_cyc = cyc;
        end
        deliver = 1'b0;
        if (bus.imem_rvalid) begin
            memq.delete(0);
            if (drop > 0 || bus.redirect) discard_cnt++;
            if (drop > 0) begin
                drop--;
                last_drop_cyc = cyc;
            end else if (!bus.redirect) begin
                deliver = 1'b1;
                occ++;
            end
        end
        if (bus.imem_req && bus.imem_gnt) begin
            r = cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)));
            if (r < last_ready) r = last_ready;
            last_ready = r;
            memq.push_back('{addr: bus.imem_addr, ready: r});
            glog.push_back(bus.imem_addr);
            exp_fetch += 32'd4;
            if (first_grant < 0) first_grant = cyc;
        end
        if (bus.redirect) begin
            occ       = 0;
            drop      = memq.size();
            exp_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
            exp_issue = exp_fetch;
            req_watch = 1'b1;
        end
        prev_stall    = bus.stall;
        prev_redirect = bus.redirect;
        prev_occ      = occ_pre;
        prev_deliver  = deliver;
        prev_ir       = bus.ir;
        prev_pc       = bus.pc;
        prev_valid    = bus.ir_valid;
        have_prev     = 1'b1;
        since++;
    endtask

    task automatic tick();
        @(negedge clk);
        rst             = rst_cmd;
        bus.stall       = stall_cmd;
        bus.redirect    = redir_cmd;
        bus.redirect_pc = redir_pc_cmd;
        bus.imem_gnt    = (int'($urandom_range(99)) < gnt_pct);
        if (memq.size() > 0 && memq[0].ready <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memq[0].addr ^ KEY;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        if (!rst_cmd) observe();
        cyc++;
    endtask

    task automatic apply_reset();
        rst_cmd   = 1'b1;
        redir_cmd = 1'b0;
        stall_cmd = 1'b0;
        memq.delete();
        repeat (3) tick();
        rst_cmd = 1'b0;
        memq.delete();
        glog.delete();
        occ = 0; drop = 0; last_ready = 0;
        exp_fetch = RESET_PC; exp_issue = RESET_PC;
        have_prev = 1'b0; since = 0;
        first_grant = -1; first_valid = -1; req_watch = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redir_cmd    = 1'b1;
        redir_pc_cmd = target;
        tick();
        redir_cmd    = 1'b0;
    endtask

    initial begin
        int c0, n0, g0, bound;
        logic [31:0] a0;
        rst = 1'b1;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        redir_pc_cmd = '0; gnt_pct = 100; lat_min = 1; lat_max = 1; issued = 0;
        discard_cnt = 0; last_drop_cyc = -1; first_req_cyc = -1; last_issue_pc = '0;

        // Reset, then free-run with a 1-cycle memory
        apply_reset();
        c0 = cyc;
        tick();
        check_reset_values();
        repeat (12) tick();
        chk("first_request_cycle", 32'(first_grant - c0), 32'd1);
        chk("grant_to_ir_latency", 32'(first_valid - first_grant), BYP ? 32'd2 : 32'd3);
        n0 = issued;
        repeat (10) tick();
        chk("throughput_1_per_cycle", 32'(issued - n0), 32'd10);

        // Six-cycle stall: buffer fills to DEPTH and nothing is lost on release
        g0 = glog.size();
        stall_cmd = 1'b1;
        repeat (6) tick();
        chk("stall_buffer_full", 32'(occ + memq.size()), 32'(DEPTH));
        chk("stall_grants_bounded", 32'(glog.size() - g0 <= int'(DEPTH)), 32'd1);
        stall_cmd = 1'b0;
        repeat (10) tick();

        // Redirect to 0x100 with three reads outstanding on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        redirect_to(32'h40);
        bound = 0;
        while (memq.size() != 3 && bound < 40) begin tick(); bound++; end
        chk("three_in_flight_reached", 32'(memq.size()), 32'd3);
        discard_cnt = 0; first_req_cyc = -1;
        n0 = issued;
        redirect_to(32'h100);
        bound = 0;
        while (issued == n0 && bound < 40) begin tick(); bound++; end
        chk("redirect_first_pc", last_issue_pc, 32'h100);
        chk("redirect_discarded", 32'(discard_cnt), 32'd3);
        chk("restart_after_last_drop", 32'(first_req_cyc - last_drop_cyc), 32'd1);
        repeat (6) tick();

        // Redirect and stall in the same cycle
        lat_min = 1; lat_max = 1;
        stall_cmd = 1'b1;
        redirect_to(32'h200);
        tick();
        chk("redir_stall_ir", bus.ir, 32'h0);
        chk("redir_stall_valid", 32'(bus.ir_valid), 32'h0);
        repeat (3) tick();
        stall_cmd = 1'b0;
        n0 = issued; bound = 0;
        while (issued == n0 && bound < 20) begin tick(); bound++; end
        chk("redir_stall_first_pc", last_issue_pc, 32'h200);
        repeat (4) tick();

        // Grant withheld for five cycles
        a0 = exp_fetch;
        gnt_pct = 0;
        repeat (5) tick();
        chk("gnt_low_drained", 32'(bus.ir_valid), 32'h0);
        chk("gnt_low_addr_stable", bus.imem_addr, a0);
        gnt_pct = 100;
        repeat (6) tick();

        // Address wrap at the top of the 32-bit space
        glog.delete();
        redirect_to(32'hFFFF_FFF8);
        repeat (8) tick();
        chk("wrap_grant_count", 32'(glog.size() >= 3), 32'd1);
        if (glog.size() >= 3) begin
            chk("wrap_addr0", glog[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", glog[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", glog[2], 32'h0000_0000);
        end
        repeat (6) tick();

        // Random stalls, grants, latencies, redirects and one mid-run reset
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        n0 = issued;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                apply_reset();
                tick();
                check_reset_values();
            end
            stall_cmd    = (int'($urandom_range(99)) < 20);
            redir_cmd    = (since >= 1) && (int'($urandom_range(99)) < 3);
            redir_pc_cmd = $urandom;
            tick();
        end
        redir_cmd = 1'b0; stall_cmd = 1'b0;
        repeat (10) tick();
        chk("random_progress", 32'(issued - n0 > 500), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
